// File: rtl/phase_baseline_trigger.sv
// rtl/phase_baseline_trigger.sv - IIR baseline tracker with negative-threshold pulse trigger and holdoff
module phase_baseline_trigger #(
    parameter int HOLDOFF_LEN = 100,
    parameter int PHASE_W     = 16
) (
    input  logic                      user_clk,
    input  logic                      user_rst_n,
    input  logic signed [PHASE_W-1:0] phase_in,
    input  logic                      phase_valid,
    input  logic [31:0]               base_kq,
    input  logic signed [PHASE_W-1:0] thresh,
    output logic signed [PHASE_W-1:0] baseline,
    output logic signed [PHASE_W-1:0] phase_sub,
    output logic                      out_valid,
    output logic                      trig,
    output logic                      armed
);
    localparam int          ACC_W     = 2 * PHASE_W;
    localparam int          DIFF_W    = PHASE_W + 1;
    localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_LEN - 1);

    typedef enum logic {ST_ARMED, ST_HOLDOFF} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      init_q, init_d;
    logic [15:0]               hcnt_q, hcnt_d;
    logic                      v1_q;
    logic signed [DIFF_W-1:0]  diff_q, diff_d;
    logic signed [PHASE_W-1:0] phase_q;
    logic signed [PHASE_W-1:0] sub_q, sub_d;
    logic                      out_valid_q;
    logic                      trig_q, trig_d;

    logic [3:0]                kq;
    logic signed [ACC_W-1:0]   phase_ext;
    logic signed [ACC_W:0]     err;
    logic signed [ACC_W:0]     step;
    logic signed [PHASE_W-1:0] sat_sub;
    logic                      unused_bits;

    assign kq          = base_kq[3:0];
    assign baseline    = acc_q[ACC_W-1 -: PHASE_W];
    assign diff_d      = {phase_in[PHASE_W-1], phase_in} - {baseline[PHASE_W-1], baseline};
    assign phase_ext   = {phase_q, {PHASE_W{1'b0}}};
    // One extra bit keeps the error exact; after the shift it fits back in the accumulator.
    assign err         = {phase_ext[ACC_W-1], phase_ext} - {acc_q[ACC_W-1], acc_q};
    assign step        = err >>> kq;
    assign unused_bits = ^{base_kq[31:4], step[ACC_W]};

    always_comb begin
        sat_sub = diff_q[PHASE_W-1:0];
        if (diff_q[DIFF_W-1] != diff_q[DIFF_W-2]) begin
            sat_sub = diff_q[DIFF_W-1] ? {1'b1, {(PHASE_W-1){1'b0}}}
                                       : {1'b0, {(PHASE_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        init_d  = init_q;
        hcnt_d  = hcnt_q;
        sub_d   = sub_q;
        trig_d  = 1'b0;
        if (v1_q) begin
            sub_d = sat_sub;
            if (init_q) begin
                acc_d  = phase_ext;
                init_d = 1'b0;
            end else begin
                case (state_q)
                    ST_ARMED: begin
                        if (sat_sub < thresh) begin
                            trig_d  = 1'b1;
                            hcnt_d  = HOLD_LOAD;
                            state_d = ST_HOLDOFF;
                        end else if (kq != 4'd0) begin
                            acc_d = acc_q + step[ACC_W-1:0];
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hcnt_q == 16'd0) begin
                            state_d = ST_ARMED;
                        end else begin
                            hcnt_d = hcnt_q - 16'd1;
                        end
                    end
                    default: state_d = ST_ARMED;
                endcase
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q     <= ST_ARMED;
            acc_q       <= '0;
            init_q      <= 1'b1;
            hcnt_q      <= '0;
            v1_q        <= 1'b0;
            diff_q      <= '0;
            phase_q     <= '0;
            sub_q       <= '0;
            out_valid_q <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            init_q      <= init_d;
            hcnt_q      <= hcnt_d;
            v1_q        <= phase_valid;
            if (phase_valid) begin
                diff_q  <= diff_d;
                phase_q <= phase_in;
            end
            sub_q       <= sub_d;
            out_valid_q <= v1_q;
            trig_q      <= trig_d;
        end
    end

    assign phase_sub = sub_q;
    assign out_valid = out_valid_q;
    assign trig      = trig_q;
    assign armed     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_phase_baseline_trigger.sv
// tb/tb_phase_baseline_trigger.sv - directed and randomized self-checking bench for phase_baseline_trigger
module tb_phase_baseline_trigger;
    localparam int HL = 4;

    logic               user_clk = 1'b0;
    logic               user_rst_n = 1'b0;
    logic signed [15:0] phase_in = '0;
    logic               phase_valid = 1'b0;
    logic [31:0]        base_kq = 32'd4;
    logic signed [15:0] thresh = -16'sd500;
    logic signed [15:0] baseline;
    logic signed [15:0] phase_sub;
    logic               out_valid;
    logic               trig;
    logic               armed;

    phase_baseline_trigger #(.HOLDOFF_LEN(HL), .PHASE_W(16)) dut (
        .user_clk(user_clk), .user_rst_n(user_rst_n), .phase_in(phase_in),
        .phase_valid(phase_valid), .base_kq(base_kq), .thresh(thresh),
        .baseline(baseline), .phase_sub(phase_sub), .out_valid(out_valid),
        .trig(trig), .armed(armed)
    );

    always #5 user_clk = ~user_clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: Q16.16 accumulator as a plain int, holdoff as "samples still blocked".
    int m_acc = 0;
    bit m_init = 1'b1;
    int m_blocked = 0;
    bit m_pend = 1'b0;
    int m_pend_diff = 0;
    int m_pend_phase = 0;
    bit e_valid = 1'b0;
    bit e_trig = 1'b0;
    int e_sub = 0;

    int cyc_n = 0;
    int q_base[$], q_sub[$], q_trig[$], q_armed[$], q_in_cyc[$], q_out_cyc[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic clr();
        q_base.delete(); q_sub.delete(); q_trig.delete(); q_armed.delete();
        q_in_cyc.delete(); q_out_cyc.delete();
    endtask

    task automatic cyc(input bit rst_n, input bit v, input int ph);
        int     nd;
        int     kqv;
        longint d;
        user_rst_n  = rst_n;
        phase_valid = v;
        phase_in    = ph[15:0];
        if (v && rst_n) q_in_cyc.push_back(cyc_n);
        @(posedge user_clk);
        cyc_n++;
        if (!rst_n) begin
            m_acc = 0; m_init = 1'b1; m_blocked = 0; m_pend = 1'b0;
            e_valid = 1'b0; e_trig = 1'b0; e_sub = 0;
        end else begin
            nd      = ph - (m_acc >>> 16);
            e_valid = m_pend;
            e_trig  = 1'b0;
            if (m_pend) begin
                e_sub = sat16(m_pend_diff);
                kqv   = int'(base_kq[3:0]);
                if (m_init) begin
                    m_acc  = m_pend_phase * 65536;
                    m_init = 1'b0;
                end else if (m_blocked > 0) begin
                    m_blocked--;
                end else if (e_sub < int'(thresh)) begin
                    e_trig    = 1'b1;
                    m_blocked = HL;
                end else if (kqv != 0) begin
                    d     = longint'(m_pend_phase) * 64'sd65536 - longint'(m_acc);
                    m_acc = int'(longint'(m_acc) + (d >>> kqv));
                end
            end
            m_pend = v;
            if (v) begin
                m_pend_diff  = nd;
                m_pend_phase = ph;
            end
        end
        #1;
        chk("out_valid", out_valid, int'(e_valid));
        chk("trig", trig, int'(e_trig));
        chk("armed", armed, int'(m_blocked == 0));
        chk("baseline", $signed(baseline), m_acc >>> 16);
        chk("phase_sub", $signed(phase_sub), e_sub);
        if (out_valid === 1'b1) begin
            q_base.push_back(int'($signed(baseline)));
            q_sub.push_back(int'($signed(phase_sub)));
            q_trig.push_back(int'(trig));
            q_armed.push_back(int'(armed));
            q_out_cyc.push_back(cyc_n);
        end
    endtask

    initial begin
        int bad;
        int ph;
        int step_base[5]  = '{0, 8192, 12288, 14336, 15360};
        int step_sub[5]   = '{0, 16384, 16384, 8192, 4096};
        int hold_trig[11] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int hold_arm[11]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int gap_trig[7]   = '{0, 1, 0, 0, 0, 0, 1};

        // reset state
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_trig", trig, 0);
        chk("rst_armed", armed, 1);
        chk("rst_baseline", $signed(baseline), 0);
        chk("rst_phase_sub", $signed(phase_sub), 0);

        // init load then steady input
        base_kq = 32'd4; thresh = -16'sd500; clr();
        cyc(1, 1, 1000); cyc(1, 0, 0);
        repeat (50) cyc(1, 1, 1000);
        cyc(1, 0, 0); cyc(1, 0, 0);
        chk("init_count", q_base.size(), 51);
        chk("init_baseline", q_base[0], 1000);
        chk("init_first_sub", q_sub[0], 1000);
        chk("init_trig", q_trig[0], 0);
        bad = 0;
        for (int i = 1; i < 51; i++)
            if (q_sub[i] != 0 || q_trig[i] != 0 || q_base[i] != 1000) bad++;
        chk("init_steady_bad", bad, 0);

        // step response with kq = 1 (stale baseline visible in phase_sub)
        cyc(0, 0, 0); base_kq = 32'd1; clr();
        cyc(1, 1, 0); cyc(1, 0, 0);
        repeat (4) cyc(1, 1, 16384);
        cyc(1, 0, 0); cyc(1, 0, 0);
        chk("step_count", q_base.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("step_baseline", q_base[i], step_base[i]);
            chk("step_sub", q_sub[i], step_sub[i]);
        end

        // trigger and holdoff, back-to-back samples
        cyc(0, 0, 0); base_kq = 32'd4; thresh = -16'sd500; clr();
        cyc(1, 1, 0); cyc(1, 0, 0);
        repeat (10) cyc(1, 1, -600);
        cyc(1, 0, 0); cyc(1, 0, 0);
        chk("hold_count", q_base.size(), 11);
        for (int i = 0; i < 11; i++) begin
            chk("hold_trig", q_trig[i], hold_trig[i]);
            chk("hold_armed", q_armed[i], hold_arm[i]);
            chk("hold_baseline", q_base[i], 0);
        end

        // saturation both directions, baseline frozen by kq = 0
        cyc(0, 0, 0); base_kq = 32'd0; clr();
        cyc(1, 1, 32767); cyc(1, 0, 0); cyc(1, 1, -32768); cyc(1, 0, 0); cyc(1, 0, 0);
        chk("sat_neg", q_sub[1], -32768);
        chk("sat_neg_base", q_base[1], 32767);
        cyc(0, 0, 0); clr();
        cyc(1, 1, -32768); cyc(1, 0, 0); cyc(1, 1, 32767); cyc(1, 0, 0); cyc(1, 0, 0);
        chk("sat_pos", q_sub[1], 32767);
        chk("sat_pos_base", q_base[1], -32768);

        // gapped valids: latency and holdoff counting valids only
        cyc(0, 0, 0); base_kq = 32'd4; clr();
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        repeat (6) begin cyc(1, 1, -600); cyc(1, 0, 0); cyc(1, 0, 0); end
        chk("gap_count", q_out_cyc.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk("gap_latency", q_out_cyc[i] - q_in_cyc[i], 2);
            chk("gap_trig", q_trig[i], gap_trig[i]);
        end

        // reset in the middle of holdoff with a sample in flight
        cyc(0, 0, 0); clr();
        cyc(1, 1, 0); cyc(1, 0, 0);
        cyc(1, 1, -600); cyc(1, 1, -600); cyc(1, 1, -600);
        chk("mid_armed_low", armed, 0);
        cyc(0, 1, -600);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_trig", trig, 0);
        chk("mid_rst_sub", $signed(phase_sub), 0);
        chk("mid_rst_base", $signed(baseline), 0);
        chk("mid_rst_armed", armed, 1);
        cyc(1, 0, 0);
        chk("mid_flush", out_valid, 0);
        clr();
        cyc(1, 1, 5000); cyc(1, 0, 0);
        chk("mid_reload_base", q_base[0], 5000);
        chk("mid_reload_sub", q_sub[0], 5000);
        chk("mid_reload_trig", q_trig[0], 0);

        // randomized traffic against the model
        cyc(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) base_kq = $urandom;
            if ($urandom_range(0, 99) == 0) thresh = 16'(-int'($urandom_range(0, 3000)));
            case ($urandom_range(0, 9))
                0:       ph = int'($urandom_range(0, 65535)) - 32768;
                1, 2:    ph = -int'($urandom_range(1000, 8000));
                default: ph = int'($urandom_range(0, 2000)) - 1000;
            endcase
            if ($urandom_range(0, 299) == 0) cyc(0, $urandom_range(0, 1) == 1, ph);
            else cyc(1, $urandom_range(0, 9) < 7, ph);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/phase_baseline_trigger.md
# phase_baseline_trigger

Per-channel photon-pulse trigger for the capture path. It tracks a slow IIR baseline of the incoming phase stream and subtracts it from each sample. When the baseline-subtracted phase crosses a programmable negative threshold, it emits a single-cycle trigger and then holds off. The block sits directly downstream of the `capture1_base_kq` software register. That register's 32-bit output, already in `user_clk` domain, drives `base_kq` here and sets the baseline filter time constant.

## Interface
Parameters:
- `HOLDOFF_LEN`, default 100: valid samples ignored after a trigger; legal range 1..65535.
- `PHASE_W`, default 16: phase sample width, two's complement.

Ports:
- `user_clk`  in  1  sole clock.
- `user_rst_n`  in  1  reset; synchronous, active-low.
- `phase_in`  in  PHASE_W  signed phase sample.
- `phase_valid`  in  1  `phase_in` qualifier; arbitrary gaps allowed.
- `base_kq`  in  32  filter config from software register; bits [3:0] = shift `kq`; bits [31:4] ignored.
- `thresh`  in  PHASE_W  signed trigger threshold; software programs it negative.
- `baseline`  out  PHASE_W  current baseline, acc[31:16].
- `phase_sub`  out  PHASE_W  saturated `phase - baseline`.
- `out_valid`  out  1  qualifies `phase_sub`, `baseline`, `trig`.
- `trig`  out  1  one-cycle trigger, coincident with `out_valid`.
- `armed`  out  1  high in ARMED state.

## Operation
- Accumulator `acc`: 32-bit signed, Q16.16; `baseline` = acc[31:16].
- Stage 1, on `phase_valid`:
  - `diff` = `phase_in` − `baseline`, computed 17-bit signed.
  - Register `diff_r`, `phase_r`, `v1`.
  - `baseline` is sampled in this same cycle.
- Stage 2, on `v1`:
  - `phase_sub` = `diff_r` saturated to [−32768, 32767].
  - Trigger FSM step.
  - Baseline update.
  - `out_valid` = 1.
- Baseline update, performed only when state = ARMED and not triggering this sample:
  - `acc` += ((`phase_r`<<16) − `acc`) >>> `kq`.
  - The difference is computed 33-bit; the result wraps to 32 bits and cannot overflow for in-range inputs.
  - `kq` = 0: no update; baseline frozen.
- First-sample load:
  - `init` flag is set at reset.
  - The first stage-2 sample loads `acc` = `phase_r`<<16 and clears `init`.
  - No trigger is possible on that sample; `phase_sub` is still output, computed against 0.
- FSM states:
  - ARMED: if `phase_sub` < `thresh` (signed, strict), then `trig` = 1, load `hcnt` = HOLDOFF_LEN−1, go to HOLDOFF.
  - HOLDOFF: baseline frozen, `trig` = 0. Each stage-2 valid: if `hcnt` = 0 go to ARMED, else decrement. So exactly HOLDOFF_LEN valid samples after the trigger sample are blocked.
- `base_kq` and `thresh` are sampled live at stage 2; a change takes effect on the next valid sample. No shadowing.

## Timing
- Latency: `phase_in` valid at cycle n → `out_valid`/`trig` at cycle n+2. Throughput: 1 sample/cycle.
- Back-to-back valids: sample n+1's `diff` uses the baseline before sample n's update (one-sample stale). This is required behaviour, not a bug.
- Reset values:
  - `acc` = 0; `init` = 1.
  - State = ARMED; `hcnt` = 0.
  - `v1` = 0.
  - All outputs 0, except `armed` = 1.
- Reset mid-stream: pipeline flushed. No `out_valid` on the cycle after reset release, even if `v1` was set.
- `trig` never asserts without `out_valid`, and never on two consecutive valid samples.
- `phase_valid` low: pipeline registers hold; `out_valid` = 0; `trig` = 0.

## Test plan
- Init load:
  - Stimulus: reset; first sample 1000; `kq` = 4.
  - Required: `baseline` = 1000 after that sample, `trig` = 0.
  - Stimulus: then constant 1000 for 50 samples.
  - Required: `phase_sub` = 0 throughout, no `trig`.
- Step response:
  - Stimulus: baseline 0 (first sample 0), then constant 16384 with `kq` = 1.
  - Required: `acc` halves the error each valid: `baseline` = 8192, 12288, 14336, ...
- Trigger/holdoff:
  - Config: `thresh` = −500, HOLDOFF_LEN = 4, baseline 0.
  - Stimulus: samples −600 ×10.
  - Required: `trig` on samples 0 and 5 only; `baseline` unchanged during HOLDOFF; `armed` low for 4 valids.
- Saturation:
  - Stimulus: baseline held at 32767 (`kq` = 0), input −32768.
  - Required: `phase_sub` = −32768, not wrapped.
- Gapped valid plus latency:
  - Stimulus: `phase_valid` 1-0-0-1.
  - Required: `out_valid` exactly 2 cycles after each; `hcnt` counts valids, not cycles.
- Reset mid-holdoff:
  - Stimulus: assert `user_rst_n` = 0 for 1 cycle with `hcnt` = 2.
  - Required: all outputs 0, `armed` = 1; next sample reloads baseline.
